pipelined_adder: RTL

//  Parametrised, pipelined add/subtract unit; successor to the fixed 128-bit ripple adder.

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice sizing and configuration legality.
package adder_pkg;

  function automatic int slice_width(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice; also reports the carry into its MSB for overflow detection.
module adder_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum   = total[W-1:0];
    cout  = total[W];
    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the XOR
    c_msb = total[W-1] ^ a[W-1] ^ b[W-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES slices, one slice per pipeline stage.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; the pipeline advances as a whole.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  generate
    if (!split_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end
  endgenerate

  logic   adv;
  logic   accept;
  stage_t src   [STAGES];
  stage_t stg_d [STAGES];
  stage_t stg_q [STAGES];

  logic [STAGES-1:0][SLICE-1:0] sl_sum;
  logic [STAGES-1:0]            sl_cout;
  logic [STAGES-1:0]            sl_cmsb;

  logic overflow_d, overflow_q;
  logic zero_d, zero_q;

  assign adv      = ~stg_q[LAST].valid | out_ready;
  assign in_ready = adv & ~flush;
  assign accept   = in_valid & in_ready;

  // Unaccepted operands are zeroed so idle bubbles never carry X toward the outputs.
  always_comb begin
    src[0].valid = accept;
    src[0].carry = accept & c_in;
    src[0].a     = accept ? a : '0;
    src[0].b     = accept ? (invert_b ? ~b : b) : '0;
    src[0].s     = '0;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stg_q[k-1];
    end
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_slice
      adder_slice #(.W(SLICE)) u_slice (
        .a     (src[g].a[g*SLICE +: SLICE]),
        .b     (src[g].b[g*SLICE +: SLICE]),
        .cin   (src[g].carry),
        .sum   (sl_sum[g]),
        .cout  (sl_cout[g]),
        .c_msb (sl_cmsb[g])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k] = stg_q[k];
      if (adv) begin
        stg_d[k]                     = src[k];
        stg_d[k].s[k*SLICE +: SLICE] = sl_sum[k];
        stg_d[k].carry               = sl_cout[k];
      end
      if (flush) begin
        stg_d[k].valid = 1'b0;
      end
    end
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if (adv) begin
      overflow_d = sl_cmsb[LAST] ^ sl_cout[LAST];
      zero_d     = (stg_d[LAST].s == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = stg_q[LAST].valid;
  assign sum       = stg_q[LAST].s;
  assign c_out     = stg_q[LAST].carry;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
